// File: rtl/pit8253_bus_master_if.sv
// pit8253_bus_master_if: command/response handshake and pit8253 register bus
interface pit8253_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [1:0]  cmd_chan;
  logic [1:0]  cmd_rl;
  logic [2:0]  cmd_mode;
  logic        cmd_bcd;
  logic [15:0] cmd_value;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic        busy;
  logic [1:0]  pit_a;
  logic        pit_wr;
  logic        pit_rd;
  logic [7:0]  pit_dout;
  logic [7:0]  pit_din;
  modport master (
    input  cmd_valid, cmd_op, cmd_chan, cmd_rl, cmd_mode, cmd_bcd, cmd_value, pit_din,
    output cmd_ready, rsp_valid, rsp_err, rsp_data, busy, pit_a, pit_wr, pit_rd, pit_dout
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_chan, cmd_rl, cmd_mode, cmd_bcd, cmd_value, pit_din,
    input  cmd_ready, rsp_valid, rsp_err, rsp_data, busy, pit_a, pit_wr, pit_rd, pit_dout
  );
endinterface

// File: rtl/pit8253_bus_master.sv
// pit8253_bus_master: sequences control word and count bytes onto the pit8253 bus per command
module pit8253_bus_master #(
  parameter int GAP_CE  = 1,
  parameter int RD_HOLD = 2
) (
  input logic clk,
  input logic reset,
  input logic ce,
  pit8253_bus_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, CW, LSB_WR, MSB_WR, RD_LSB, RD_MSB, GAP, RESP} state_t;
  state_t state_q, state_d, ret_q, ret_d;
  logic pend_q, pend_d, op_q, op_d, err_q, err_d, wr_q, wr_d, rd_q, rd_d;
  logic [1:0] chan_q, chan_d, rl_q, rl_d, a_q, a_d;
  logic [7:0] cw_q, cw_d, dout_q, dout_d, cnt_q, cnt_d;
  logic [15:0] val_q, val_d, data_q, data_d;
  logic accept, illegal, last_gap, last_rd;
  assign bus.cmd_ready = state_q == IDLE && !pend_q;
  assign bus.busy = !bus.cmd_ready;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_err = err_q;
  assign bus.rsp_data = data_q;
  assign bus.pit_a = a_q;
  assign bus.pit_wr = wr_q;
  assign bus.pit_rd = rd_q;
  assign bus.pit_dout = dout_q;
  always_comb begin
    state_d = state_q;
    ret_d = ret_q;
    pend_d = pend_q;
    op_d = op_q;
    err_d = err_q;
    wr_d = wr_q;
    rd_d = rd_q;
    chan_d = chan_q;
    rl_d = rl_q;
    a_d = a_q;
    cw_d = cw_q;
    dout_d = dout_q;
    cnt_d = cnt_q;
    val_d = val_q;
    data_d = data_q;
    accept = bus.cmd_valid && bus.cmd_ready;
    illegal = bus.cmd_chan == 2'd3 || (!bus.cmd_op && bus.cmd_rl == 2'd0);
    last_gap = cnt_q == 8'(GAP_CE - 1);
    last_rd = cnt_q == 8'(RD_HOLD - 1);
    if (accept) begin
      op_d = bus.cmd_op;
      chan_d = bus.cmd_chan;
      rl_d = bus.cmd_rl;
      val_d = bus.cmd_value;
      cw_d = bus.cmd_op ? {bus.cmd_chan, 6'b0} : {bus.cmd_chan, bus.cmd_rl, bus.cmd_mode, bus.cmd_bcd};
      err_d = illegal;
      data_d = '0;
      pend_d = !illegal;
      state_d = illegal ? RESP : IDLE;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end else if (ce) begin
      case (state_q)
        IDLE: if (pend_q) begin
          pend_d = 1'b0;
          state_d = CW;
          wr_d = 1'b1;
          a_d = 2'd3;
          dout_d = cw_q;
        end
        CW, LSB_WR, MSB_WR: begin
          wr_d = 1'b0;
          state_d = GAP;
          cnt_d = '0;
          ret_d = state_q == MSB_WR ? RESP :
                  state_q == LSB_WR ? (rl_q[1] ? MSB_WR : RESP) :
                  op_q ? RD_LSB : (rl_q[0] ? LSB_WR : MSB_WR);
        end
        RD_LSB, RD_MSB: begin
          cnt_d = last_rd ? '0 : cnt_q + 8'd1;
          if (last_rd) begin
            rd_d = 1'b0;
            state_d = GAP;
            ret_d = state_q == RD_LSB ? RD_MSB : RESP;
            data_d = state_q == RD_LSB ? {data_q[15:8], bus.pit_din} : {bus.pit_din, data_q[7:0]};
          end
        end
        GAP: begin
          cnt_d = last_gap ? '0 : cnt_q + 8'd1;
          if (last_gap) begin
            state_d = ret_q;
            wr_d = ret_q inside {LSB_WR, MSB_WR};
            rd_d = ret_q inside {RD_LSB, RD_MSB};
            a_d = ret_q == RESP ? a_q : chan_q;
            dout_d = ret_q == LSB_WR ? val_q[7:0] : ret_q == MSB_WR ? val_q[15:8] : dout_q;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      pend_q <= 1'b0;
      op_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      chan_q <= '0;
      rl_q <= '0;
      a_q <= '0;
      cw_q <= '0;
      dout_q <= '0;
      cnt_q <= '0;
      val_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      pend_q <= pend_d;
      op_q <= op_d;
      err_q <= err_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      chan_q <= chan_d;
      rl_q <= rl_d;
      a_q <= a_d;
      cw_q <= cw_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
      val_q <= val_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_pit8253_bus_master.sv
// tb_pit8253_bus_master: scoreboard bench checking bus strobes and responses against spec
module tb_pit8253_bus_master;
  typedef struct packed {logic rd; logic [1:0] a; logic [7:0] d;} ev_t;
  typedef struct packed {logic err; logic [15:0] data;} rsp_t;
  logic clk = 0, reset = 1, ce = 0;
  pit8253_bus_master_if bus();
  pit8253_bus_master #(.GAP_CE(1), .RD_HOLD(2)) dut (.clk(clk), .reset(reset), .ce(ce), .bus(bus));
  ev_t exp_ev[$];
  rsp_t exp_rsp[$];
  logic [7:0] rd_vals[$];
  int n_chk = 0, n_fail = 0, rsp_seen = 0, hi_n = 0, lo_n = 100;
  logic prev = 0;
  ev_t cur, now_ev, e;
  rsp_t r;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 ce = ~ce;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reset) begin
      hi_n = 0;
      lo_n = 100;
      prev = 0;
      bus.pit_din = 8'h00;
    end else begin
      check("wr_rd_excl", 32'(bus.pit_wr & bus.pit_rd), 0);
      now_ev = '{bus.pit_rd, bus.pit_a, bus.pit_wr ? bus.pit_dout : 8'h00};
      if ((bus.pit_wr | bus.pit_rd) && !prev) begin
        check("gap_before", 32'(lo_n >= 2), 1);
        check("ev_pending", 32'(exp_ev.size() > 0), 1);
        if (exp_ev.size() > 0) begin
          e = exp_ev.pop_front();
          check("bus_event", 32'(now_ev), 32'(e));
        end
        if (bus.pit_rd && rd_vals.size() > 0) bus.pit_din = rd_vals.pop_front();
        cur = now_ev;
        hi_n = 1;
      end else if (bus.pit_wr | bus.pit_rd) begin
        check("strobe_hold", 32'(now_ev), 32'(cur));
        hi_n++;
      end else if (prev) begin
        check("strobe_width", 32'(hi_n), cur.rd ? 32'd4 : 32'd2);
        lo_n = 1;
      end else lo_n++;
      prev = bus.pit_wr | bus.pit_rd;
      if (bus.rsp_valid) begin
        check("rsp_pending", 32'(exp_rsp.size() > 0), 1);
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          check("rsp", 32'({bus.rsp_err, bus.rsp_data}), 32'(r));
        end
        rsp_seen++;
      end
    end
  end
  task automatic send(input logic op, input logic [1:0] chan, input logic [1:0] rl,
                      input logic [2:0] mode, input logic bcd, input logic [15:0] val,
                      input logic [7:0] r0, input logic [7:0] r1, input bit wait_rsp);
    logic ill;
    int n0;
    ill = chan == 2'd3 || (!op && rl == 2'd0);
    if (!ill) begin
      exp_ev.push_back(op ? '{1'b0, 2'd3, {chan, 6'b0}} : '{1'b0, 2'd3, {chan, rl, mode, bcd}});
      if (op) begin
        exp_ev.push_back('{1'b1, chan, 8'h00});
        exp_ev.push_back('{1'b1, chan, 8'h00});
        rd_vals.push_back(r0);
        rd_vals.push_back(r1);
      end else begin
        if (rl[0]) exp_ev.push_back('{1'b0, chan, val[7:0]});
        if (rl[1]) exp_ev.push_back('{1'b0, chan, val[15:8]});
      end
    end
    exp_rsp.push_back('{ill, (op && !ill) ? {r1, r0} : 16'h0000});
    @(negedge clk);
    for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
    check("ready_before_cmd", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1;
    bus.cmd_op = op;
    bus.cmd_chan = chan;
    bus.cmd_rl = rl;
    bus.cmd_mode = mode;
    bus.cmd_bcd = bcd;
    bus.cmd_value = val;
    n0 = rsp_seen;
    @(posedge clk);
    #1;
    bus.cmd_valid = 0;
    bus.cmd_op = 1'($urandom);
    bus.cmd_chan = 2'($urandom);
    bus.cmd_rl = 2'($urandom);
    bus.cmd_mode = 3'($urandom);
    bus.cmd_value = 16'($urandom);
    if (wait_rsp) begin
      for (int i = 0; i < 300 && rsp_seen == n0; i++) @(negedge clk);
      check("rsp_timeout", 32'(rsp_seen != n0), 1);
      @(negedge clk);
      check("ready_after_rsp", 32'(bus.cmd_ready), 1);
    end
  endtask
  initial begin
    bus.cmd_valid = 0;
    bus.cmd_op = 0;
    bus.cmd_chan = 0;
    bus.cmd_rl = 0;
    bus.cmd_mode = 0;
    bus.cmd_bcd = 0;
    bus.cmd_value = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_data}), 0);
    check("rst_pit", 32'({bus.pit_a, bus.pit_wr, bus.pit_rd, bus.pit_dout}), 0);
    reset = 0;
    send(0, 2'd0, 2'b11, 3'd3, 0, 16'h1234, 8'h00, 8'h00, 1);
    send(0, 2'd2, 2'b01, 3'd0, 0, 16'h00AB, 8'h00, 8'h00, 1);
    send(1, 2'd1, 2'b00, 3'd0, 0, 16'h0000, 8'h5A, 8'hC3, 1);
    repeat (5) @(negedge clk);
    check("rsp_data_held", 32'(bus.rsp_data), 32'h0000C35A);
    send(0, 2'd1, 2'b10, 3'd2, 1, 16'hBEEF, 8'h00, 8'h00, 1);
    send(0, 2'd3, 2'b11, 3'd1, 0, 16'h5555, 8'h00, 8'h00, 1);
    send(0, 2'd1, 2'b00, 3'd1, 0, 16'h5555, 8'h00, 8'h00, 1);
    send(1, 2'd3, 2'b00, 3'd0, 0, 16'h0000, 8'h00, 8'h00, 1);
    send(1, 2'd2, 2'b00, 3'd0, 0, 16'h0000, 8'hFF, 8'h01, 1);
    send(0, 2'd0, 2'b11, 3'd3, 0, 16'h1234, 8'h00, 8'h00, 0);
    for (int i = 0; i < 100 && !(bus.pit_wr && bus.pit_a == 2'd0 && bus.pit_dout == 8'h12); i++)
      @(negedge clk);
    #1;
    check("msb_wr_reached", 32'(bus.pit_wr && bus.pit_dout == 8'h12), 1);
    check("events_consumed", 32'(exp_ev.size()), 0);
    reset = 1;
    @(posedge clk);
    #1;
    check("rst_mid_wr", 32'({bus.pit_wr, bus.pit_rd}), 0);
    exp_rsp.delete();
    rd_vals.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    check("ready_after_rst", 32'(bus.cmd_ready), 1);
    repeat (30) @(negedge clk);
    send(1, 2'd0, 2'b00, 3'd0, 0, 16'h0000, 8'h04, 8'h00, 1);
    check("sb_ev_empty", 32'(exp_ev.size()), 0);
    check("sb_rsp_empty", 32'(exp_rsp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
